read_burst_ctrl: RTL and testbench

READ_BURST_CTRL -- requirements
Module: read_burst_ctrl

---
 rtl/read_pkg.sv | 21 ++
 rtl/rd_timeout_cnt.sv | 38 +++
 rtl/read_burst_ctrl.sv | 131 +++++++++++++
 tb/tb_read_burst_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/read_pkg.sv
// Shared types and constants for the read burst controller and its idle watchdog.
package read_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } rd_state_e;

  localparam int unsigned CNT_W           = 5;
  localparam int unsigned DEFAULT_TIMEOUT = 31;

  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [CNT_W-1:0] MAX_BEATS = 16;

  // Requests longer than the largest legal burst are trimmed so beat_cnt stays bounded.
  function automatic logic [CNT_W-1:0] clamp_beats(input logic [CNT_W-1:0] n);
    return (n > MAX_BEATS) ? MAX_BEATS : n;
  endfunction

endpackage

// File: rtl/rd_timeout_cnt.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th one.
module rd_timeout_cnt #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Expiry fires on the cycle that would bring the count to TIMEOUT.
  assign expired_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expired_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/read_burst_ctrl.sv
// Read burst controller: accepts a counted burst of beats, registers them out with
// last/done/error signalling and an idle watchdog that aborts stalled bursts.
module read_burst_ctrl
  import read_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_start_i,
  input  logic [CNT_W-1:0]  count_val_i,
  input  logic              rd_data_valid_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_data_valid_o,
  output logic              rd_last_o,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic              rd_busy_o,
  output logic              rd_done_o,
  output logic              rd_err_o
);

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic idle_clear;
  logic idle_enable;
  logic idle_expired;

  assign idle_clear  = (state_q != ST_BURST) || rd_data_valid_i;
  assign idle_enable = (state_q == ST_BURST) && !rd_data_valid_i;

  rd_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (idle_clear),
    .enable_i  (idle_enable),
    .expired_o (idle_expired)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    done_d      = (state_q == ST_DONE);
    err_d       = 1'b0;

    case (state_q)
      // DONE behaves like IDLE for new requests, so a back-to-back start is seamless.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (rd_start_i) begin
          if (count_val_i != '0) begin
            state_d     = ST_BURST;
            remaining_d = clamp_beats(count_val_i);
            beat_cnt_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_BURST: begin
        if (rd_start_i) begin
          err_d = 1'b1;
        end
        if (rd_data_valid_i) begin
          data_d      = rd_data_i;
          valid_d     = 1'b1;
          beat_cnt_d  = (beat_cnt_q == MAX_BEATS) ? beat_cnt_q : beat_cnt_q + CNT_ONE;
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            last_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else if (idle_expired) begin
          err_d       = 1'b1;
          remaining_d = '0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rd_data_o       = data_q;
  assign rd_data_valid_o = valid_q;
  assign rd_last_o       = last_q;
  assign beat_cnt_o      = beat_cnt_q;
  assign rd_busy_o       = (state_q != ST_IDLE);
  assign rd_done_o       = done_q;
  assign rd_err_o        = err_q;

endmodule

// File: tb/tb_read_burst_ctrl.sv
// Self-checking bench for read_burst_ctrl: table of burst scenarios plus corner sequences.
module tb_read_burst_ctrl;

  localparam int unsigned DATA_W = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              rd_start_i;
  logic [4:0]        count_val_i;
  logic              rd_data_valid_i;
  logic [DATA_W-1:0] rd_data_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_data_valid_o;
  logic              rd_last_o;
  logic [4:0]        beat_cnt_o;
  logic              rd_busy_o;
  logic              rd_done_o;
  logic              rd_err_o;

  always #5 clk_i = ~clk_i;

  read_burst_ctrl #(
    .DATA_W  (DATA_W),
    .TIMEOUT (31)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rd_start_i      (rd_start_i),
    .count_val_i     (count_val_i),
    .rd_data_valid_i (rd_data_valid_i),
    .rd_data_i       (rd_data_i),
    .rd_data_o       (rd_data_o),
    .rd_data_valid_o (rd_data_valid_o),
    .rd_last_o       (rd_last_o),
    .beat_cnt_o      (beat_cnt_o),
    .rd_busy_o       (rd_busy_o),
    .rd_done_o       (rd_done_o),
    .rd_err_o        (rd_err_o)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [4:0]        cnt;
  } beat_t;

  typedef struct {
    logic [4:0]  count;
    int          gap_every;
    int          gap_len;
    logic [15:0] base;
    int          exp_done;
    int          exp_err;
    logic [4:0]  exp_cnt;
  } vec_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    errors   = 0;
  int    done_cnt = 0;
  int    err_cnt  = 0;
  logic  prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every delivered beat and checks done timing.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_last = 1'b0;
    end else begin
      if (rd_data_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {31'd0, rd_data_valid_o}, 32'd0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", {16'd0, rd_data_o}, {16'd0, b.data});
          check("beat_last", {31'd0, rd_last_o}, {31'd0, b.last});
          check("beat_cnt", {27'd0, beat_cnt_o}, {27'd0, b.cnt});
        end
      end else if (rd_last_o) begin
        check("last_without_valid", {31'd0, rd_last_o}, 32'd0);
      end
      if (rd_done_o || prev_last) begin
        check("done_after_last", {31'd0, rd_done_o}, {31'd0, prev_last});
      end
      done_cnt += int'(rd_done_o);
      err_cnt  += int'(rd_err_o);
      prev_last = rd_last_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_start(input logic [4:0] n);
    rd_start_i  = 1'b1;
    count_val_i = n;
    @(negedge clk_i);
    rd_start_i  = 1'b0;
    count_val_i = '0;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last, input logic [4:0] cnt);
    beat_t b;
    b.data = d;
    b.last = last;
    b.cnt  = cnt;
    exp_q.push_back(b);
    rd_data_valid_i = 1'b1;
    rd_data_i       = d;
    @(negedge clk_i);
    rd_data_valid_i = 1'b0;
  endtask

  task automatic check_deltas(input string tag, input int done0, input int err0,
                              input int exp_done, input int exp_err);
    check({tag, "_done_pulses"}, done_cnt - done0, exp_done);
    check({tag, "_err_pulses"}, err_cnt - err0, exp_err);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int done0;
    int err0;

    rst_i           = 1'b1;
    rd_start_i      = 1'b0;
    count_val_i     = '0;
    rd_data_valid_i = 1'b0;
    rd_data_i       = '0;

    vecs[0] = '{count: 5'd4,  gap_every: 0, gap_len: 0,  base: 16'h00A0, exp_done: 1, exp_err: 0, exp_cnt: 5'd4};
    vecs[1] = '{count: 5'd9,  gap_every: 3, gap_len: 3,  base: 16'h0100, exp_done: 1, exp_err: 0, exp_cnt: 5'd9};
    vecs[2] = '{count: 5'd1,  gap_every: 0, gap_len: 0,  base: 16'h0200, exp_done: 1, exp_err: 0, exp_cnt: 5'd1};
    vecs[3] = '{count: 5'd16, gap_every: 5, gap_len: 30, base: 16'h0300, exp_done: 1, exp_err: 0, exp_cnt: 5'd16};
    vecs[4] = '{count: 5'd0,  gap_every: 0, gap_len: 0,  base: 16'h0000, exp_done: 0, exp_err: 1, exp_cnt: 5'd16};

    idle(2);
    check("reset_valid", {31'd0, rd_data_valid_o}, 32'd0);
    check("reset_data", {16'd0, rd_data_o}, 32'd0);
    check("reset_busy", {31'd0, rd_busy_o}, 32'd0);
    check("reset_cnt", {27'd0, beat_cnt_o}, 32'd0);
    check("reset_flags", {29'd0, rd_last_o, rd_done_o, rd_err_o}, 32'd0);
    rst_i = 1'b0;

    for (int v = 0; v < 5; v++) begin
      done0 = done_cnt;
      err0  = err_cnt;
      do_start(vecs[v].count);
      check("busy_after_start", {31'd0, rd_busy_o}, {31'd0, (vecs[v].count != 5'd0)});
      for (int i = 0; i < int'(vecs[v].count); i++) begin
        if (vecs[v].gap_every != 0 && i != 0 && (i % vecs[v].gap_every) == 0) idle(vecs[v].gap_len);
        send_beat(vecs[v].base + 16'(i), (i == int'(vecs[v].count) - 1), 5'(i + 1));
      end
      idle(3);
      check_deltas("vec", done0, err0, vecs[v].exp_done, vecs[v].exp_err);
      check("vec_beat_cnt_final", {27'd0, beat_cnt_o}, {27'd0, vecs[v].exp_cnt});
      check("vec_idle_after", {31'd0, rd_busy_o}, 32'd0);
    end

    // Start request during an active burst is rejected without disturbing it.
    done0 = done_cnt;
    err0  = err_cnt;
    do_start(5'd16);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        rd_start_i  = 1'b1;
        count_val_i = 5'd5;
      end
      send_beat(16'h0400 + 16'(i), (i == 15), 5'(i + 1));
      rd_start_i  = 1'b0;
      count_val_i = '0;
    end
    idle(3);
    check_deltas("start_in_burst", done0, err0, 1, 1);
    check("start_in_burst_cnt", {27'd0, beat_cnt_o}, 32'd16);

    // Stalled burst: 31 idle cycles abort it; later beats are dropped.
    done0 = done_cnt;
    err0  = err_cnt;
    do_start(5'd8);
    send_beat(16'h0500, 1'b0, 5'd1);
    send_beat(16'h0501, 1'b0, 5'd2);
    idle(30);
    check("timeout_not_yet_busy", {31'd0, rd_busy_o}, 32'd1);
    check("timeout_not_yet_err", {31'd0, rd_err_o}, 32'd0);
    idle(1);
    check("timeout_err", {31'd0, rd_err_o}, 32'd1);
    check("timeout_busy", {31'd0, rd_busy_o}, 32'd0);
    check("timeout_cnt_hold", {27'd0, beat_cnt_o}, 32'd2);
    rd_data_valid_i = 1'b1;
    rd_data_i       = 16'hDEAD;
    @(negedge clk_i);
    rd_data_valid_i = 1'b0;
    idle(3);
    check_deltas("timeout", done0, err0, 0, 1);

    // Asynchronous reset in the middle of a burst, then a clean restart.
    do_start(5'd16);
    for (int i = 0; i < 5; i++) send_beat(16'h0600 + 16'(i), 1'b0, 5'(i + 1));
    #2;
    rst_i = 1'b1;
    #1;
    check("midreset_valid", {31'd0, rd_data_valid_o}, 32'd0);
    check("midreset_data", {16'd0, rd_data_o}, 32'd0);
    check("midreset_busy", {31'd0, rd_busy_o}, 32'd0);
    check("midreset_cnt", {27'd0, beat_cnt_o}, 32'd0);
    check("midreset_flags", {29'd0, rd_last_o, rd_done_o, rd_err_o}, 32'd0);
    exp_q.delete();
    idle(2);
    rst_i = 1'b0;
    done0 = done_cnt;
    err0  = err_cnt;
    do_start(5'd4);
    check("restart_busy", {31'd0, rd_busy_o}, 32'd1);
    for (int i = 0; i < 4; i++) send_beat(16'h0700 + 16'(i), (i == 3), 5'(i + 1));
    idle(3);
    check_deltas("restart", done0, err0, 1, 0);

    // New start issued in the DONE cycle of the previous burst.
    done0 = done_cnt;
    err0  = err_cnt;
    do_start(5'd16);
    for (int i = 0; i < 16; i++) send_beat(16'h0800 + 16'(i), (i == 15), 5'(i + 1));
    do_start(5'd16);
    check("done_cycle_start_done", {31'd0, rd_done_o}, 32'd1);
    check("done_cycle_start_busy", {31'd0, rd_busy_o}, 32'd1);
    for (int i = 0; i < 16; i++) send_beat(16'h0900 + 16'(i), (i == 15), 5'(i + 1));
    idle(3);
    check_deltas("done_cycle_start", done0, err0, 2, 0);
    check("done_cycle_start_cnt", {27'd0, beat_cnt_o}, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
